// File: rtl/periph_arb_pkg.sv
// Shared encodings and constants for the two-master peripheral arbiter.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned LOCK_MAX_DEF = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin winner select with a master-1 lock override.
module arb_rr2
  import periph_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       lock_ok,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = M0;
    if (lock_ok && req[1]) begin
      gnt = M1;
    end else if (req == 2'b11) begin
      gnt = ~last_gnt;
    end else if (req[1]) begin
      gnt = M1;
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// Two-master (CPU/DMA) arbiter onto a single peripheral bus: IDLE -> ACCESS -> RESP,
// registered strobes, one-cycle ack and registered read data per master.
module periph_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  input  logic        m1_lock,
  output logic        p_rd,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata
);

  localparam int unsigned CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  arb_state_e    r_state;
  logic          r_last_gnt;
  logic          r_gnt;
  logic [CW-1:0] r_lock_cnt;

  logic w_gnt;
  logic w_valid;
  logic w_lock_ok;

  assign w_lock_ok = (r_last_gnt == M1) && m1_req && m1_lock && (r_lock_cnt < LOCK_MAX_C);

  arb_rr2 u_arb (
    .req      ({m1_req, m0_req}),
    .last_gnt (r_last_gnt),
    .lock_ok  (w_lock_ok),
    .gnt      (w_gnt),
    .valid    (w_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= M1;
      r_gnt      <= M0;
      r_lock_cnt <= '0;
      p_rd       <= 1'b0;
      p_wr       <= 1'b0;
      p_addr     <= '0;
      p_wdata    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      p_rd   <= 1'b0;
      p_wr   <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state    <= ST_ACCESS;
            r_last_gnt <= w_gnt;
            r_gnt      <= w_gnt;
            p_addr     <= (w_gnt == M1) ? m1_addr  : m0_addr;
            p_wdata    <= (w_gnt == M1) ? m1_wdata : m0_wdata;
            p_rd       <= (w_gnt == M1) ? ~m1_wr   : ~m0_wr;
            p_wr       <= (w_gnt == M1) ?  m1_wr   :  m0_wr;
            // Counter tracks consecutive locked DMA grants and saturates instead of wrapping.
            if ((w_gnt == M0) || !m1_lock) begin
              r_lock_cnt <= '0;
            end else if (r_lock_cnt != LOCK_MAX_C) begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          if (r_gnt == M1) begin
            m1_ack <= 1'b1;
            if (p_rd) m1_rdata <= p_rdata;
          end else begin
            m0_ack <= 1'b1;
            if (p_rd) m0_rdata <= p_rdata;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 The module SHALL expose the following parameter: LOCK_MAX, default 4, maximum consecutive locked grants to master 1.
REQ-002 The module SHALL expose the following ports, clock and reset first:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU request.
- m0_wr  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  32  registered read data.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: DMA master, same widths and meanings as m0.
- m1_lock  in  1  master 1 requests back-to-back ownership.
- p_rd  out  1  peripheral read strobe.
- p_wr  out  1  peripheral write strobe.
- p_addr  out  32  peripheral address.
- p_wdata  out  32  peripheral write data.
- p_rdata  in  32  peripheral read data, combinational from p_addr/p_rd.

Function
REQ-003 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1 at posedge; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-004 In IDLE, the winner SHALL be chosen as follows:
- only one req high: that master wins;
- both high: master != last_gnt wins (round-robin), except REQ-006.
REQ-005 On IDLE->ACCESS, the winner's addr/wdata SHALL be registered into p_addr/p_wdata, and p_rd=~wr or p_wr=wr SHALL be registered; strobes SHALL be high for exactly the ACCESS cycle and 0 otherwise.
REQ-006 Lock rule: if last_gnt=1, m1_req=1, m1_lock=1 and lock_cnt<LOCK_MAX, master 1 SHALL win regardless of m0_req.
- lock_cnt increments per locked consecutive master-1 grant.
- lock_cnt clears on any master-0 grant or when m1_lock=0 at grant.
REQ-007 At ACCESS->RESP, read data SHALL be handled as follows:
- read: p_rdata is captured into the winner's mX_rdata;
- write: mX_rdata holds its previous value;
- the loser's mX_rdata is never modified.
REQ-008 mX_ack SHALL be high exactly in the RESP cycle for the granted master; latency is req sampled at cycle 0, strobe in cycle 1, ack and rdata valid in cycle 2.
REQ-009 Requesters SHALL hold req/wr/addr/wdata stable until ack; req high during RESP is ignored; req still high in the following IDLE cycle is a new request.
REQ-010 Bus changes during ACCESS/RESP SHALL NOT alter the registered transfer.
REQ-011 last_gnt SHALL update on every IDLE->ACCESS transition; peak throughput SHALL be one transfer per 3 cycles.
REQ-012 lock_cnt SHALL saturate at LOCK_MAX; it SHALL NOT wrap.

Reset
REQ-013 On reset=0, the following SHALL be forced immediately, independent of clk:
- state=IDLE, last_gnt=1 (master 0 wins first tie), lock_cnt=0;
- p_rd=0, p_wr=0, p_addr=0, p_wdata=0;
- m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
REQ-014 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transfer with no ack; the requester must re-issue after reset release.

Structure
REQ-015 Package periph_arb_pkg SHALL hold the state encoding, LOCK_MAX default and master index constants.
REQ-016 Winner selection SHALL be a sub-module arb_rr2, combinational: inputs req[1:0], last_gnt, lock_ok; output gnt index and valid.
REQ-017 FSM, bus registers and rdata capture SHALL live in periph_arbiter.

Verification
REQ-018 Bench SHALL drive:
- m0 read 0x40000010 with p_rdata=0x000000A5 -> p_rd high cycle 1 only, m0_ack cycle 2, m0_rdata=0xA5, m1 signals untouched.
- m0 and m1 both write (0x4000000C/0x11, 0x40000014/0x8BF) out of reset -> m0 served first, m1 next, p_wdata sequence 0x11 then 0x8BF.
- m1_lock=1 with m0_req and m1_req held continuously, LOCK_MAX=4 -> 4 consecutive m1 grants, then m0 granted, lock_cnt=0.
- m1_lock=0 with continuous dual requests -> strict alternation m0, m1, m0, m1.
- reset pulsed during ACCESS of m1 write -> no m1_ack, all outputs 0 immediately, first post-reset tie granted to m0.
- m0 write then m0 read -> write leaves m0_rdata at prior value; read updates it.
